// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch stage for the 8-entry FIFO memory.
// Issues read enables to the memory and captures the 1-cycle-latency read data
// into a small skid buffer. The buffered words are presented to the consumer as
// a first-word-fall-through valid/ready stream.
module fifo_rd_prefetch #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SKID_DEPTH = 4,
    parameter int unsigned LEVEL_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [LEVEL_W-1:0]            mem_level_i,
    input  logic [WIDTH-1:0]              mem_data_i,
    output logic                          rd_en_o,
    output logic [WIDTH-1:0]              data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(SKID_DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    logic [WIDTH-1:0] r_buf [SKID_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             r_inflight;

    logic             w_push;
    logic             w_pop;
    logic [SUM_W-1:0] w_committed;
    logic             w_mem_avail;
    logic             w_room;

    // Read issue: only registered state and the memory level feed rd_en_o.
    // The inflight read is counted against both the memory level and the
    // buffer space, so a read can never pass the write pointer or overflow.
    always_comb begin
        w_committed = SUM_W'(r_occ) + SUM_W'(r_inflight);
        w_mem_avail = (mem_level_i > LEVEL_W'(r_inflight));
        w_room      = (w_committed < SUM_W'(SKID_DEPTH));
        rd_en_o     = !rst_i && !flush_i && w_mem_avail && w_room;
        w_push      = r_inflight;
        w_pop       = valid_o && ready_i;
    end

    // Pointer, occupancy and inflight bookkeeping; flush clears like reset.
    always_ff @(posedge clk) begin
        if (rst_i || flush_i) begin
            r_occ      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rd_en_o;
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    // Skid storage: capture returning memory data; a word landing during flush is dropped.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_buf[r_tail] <= mem_data_i;
        end
    end

    assign valid_o = (r_occ != '0);
    assign data_o  = r_buf[r_head];
    assign level_o = r_occ;

endmodule
